// File: rtl/vga_pkg.sv
// Shared constants for the VGA pixel stage: source-mode encoding and the
// default 640x480 active-window timing in counter ticks.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_IMAGE = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_SOLID = 2'd3
    } mode_e;

    localparam int DEF_H_ACT_START = 575;
    localparam int DEF_H_ACT_END   = 3135;
    localparam int DEF_V_ACT_START = 31;
    localparam int DEF_V_ACT_END   = 511;
    localparam int DEF_PIX_SHIFT   = 2;

endpackage

// File: rtl/vga_pixel_stage_if.sv
// Signal bundle between the timing/pixel source and the VGA pin stage.
interface vga_pixel_stage_if #(
    parameter int CNT_W   = 12,
    parameter int COLOR_W = 4
);
    logic [CNT_W-1:0]     H_count;
    logic [CNT_W-1:0]     V_count;
    logic                 hsync_in;
    logic                 vsync_in;
    logic                 red_col;
    logic                 green_col;
    logic                 blue_col;
    logic [1:0]           mode_in;
    logic [3*COLOR_W-1:0] solid_rgb;
    logic [COLOR_W-1:0]   VGA_RED;
    logic [COLOR_W-1:0]   VGA_GREEN;
    logic [COLOR_W-1:0]   VGA_BLUE;
    logic                 VGA_HS;
    logic                 VGA_VS;
    logic                 de;
    logic                 frame_start;
    logic [1:0]           mode_q;

    modport master (
        output H_count, V_count, hsync_in, vsync_in, red_col, green_col, blue_col,
               mode_in, solid_rgb,
        input  VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HS, VGA_VS, de, frame_start, mode_q
    );

    modport slave (
        input  H_count, V_count, hsync_in, vsync_in, red_col, green_col, blue_col,
               mode_in, solid_rgb,
        output VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HS, VGA_VS, de, frame_start, mode_q
    );
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay for a bundle of signals; clears fully on reset.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift register: every stage moves one step per clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign dout = stage_r[DEPTH-1];
endmodule

// File: rtl/vga_pixel_stage.sv
// VGA colour output stage: active-window gating, frame-synchronous source
// modes, and a pipeline keeping syncs/de/frame_start aligned with colour.
module vga_pixel_stage
    import vga_pkg::*;
#(
    parameter int CNT_W       = 12,
    parameter int COLOR_W     = 4,
    parameter int H_ACT_START = DEF_H_ACT_START,
    parameter int H_ACT_END   = DEF_H_ACT_END,
    parameter int V_ACT_START = DEF_V_ACT_START,
    parameter int V_ACT_END   = DEF_V_ACT_END,
    parameter int PIX_SHIFT   = DEF_PIX_SHIFT,
    parameter int LATENCY     = 1,
    parameter int BAR_SHIFT   = 6,
    parameter int CHK_SHIFT   = 5
) (
    input logic               clk,
    input logic               reset,
    vga_pixel_stage_if.slave  vif
);
    localparam int RGB_W = 3 * COLOR_W;
    localparam int BW    = RGB_W + 4;

    logic             act_s;
    logic             fs_s;
    logic [CNT_W-1:0] hoff_s;
    logic [CNT_W-1:0] y_s;
    logic [2:0]       bar_s;
    logic             chk_s;
    mode_e            mode_eff_s;
    logic [RGB_W-1:0] rgb_s;
    mode_e            mode_r;
    logic [BW-1:0]    stage0_r;
    logic [BW-1:0]    bundle_s;

    // Window decode, pixel coordinates and colour source selection.
    always_comb begin
        act_s  = (vif.H_count >= CNT_W'(H_ACT_START)) && (vif.H_count < CNT_W'(H_ACT_END)) &&
                 (vif.V_count >= CNT_W'(V_ACT_START)) && (vif.V_count < CNT_W'(V_ACT_END));
        fs_s   = (vif.H_count == {CNT_W{1'b0}}) && (vif.V_count == {CNT_W{1'b0}});
        hoff_s = vif.H_count - CNT_W'(H_ACT_START);
        y_s    = vif.V_count - CNT_W'(V_ACT_START);
        // Bar index and checker bit come straight from the unscaled offset.
        bar_s  = 3'(hoff_s >> (PIX_SHIFT + BAR_SHIFT));
        chk_s  = 1'(hoff_s >> (PIX_SHIFT + CHK_SHIFT)) ^ 1'(y_s >> CHK_SHIFT);
        // A new mode applies from the frame-start cycle itself.
        mode_eff_s = fs_s ? mode_e'(vif.mode_in) : mode_r;
        rgb_s      = {RGB_W{1'b0}};
        if (act_s) begin
            case (mode_eff_s)
                MODE_IMAGE: rgb_s = {{COLOR_W{vif.red_col}}, {COLOR_W{vif.green_col}},
                                     {COLOR_W{vif.blue_col}}};
                MODE_BARS:  rgb_s = {{COLOR_W{bar_s[2]}}, {COLOR_W{bar_s[1]}},
                                     {COLOR_W{bar_s[0]}}};
                MODE_CHECK: rgb_s = {RGB_W{chk_s}};
                MODE_SOLID: rgb_s = vif.solid_rgb;
                default:    rgb_s = {RGB_W{1'b0}};
            endcase
        end else begin
            rgb_s = {RGB_W{1'b0}};
        end
    end

    // Stage 0: mode latch and first pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_r   <= MODE_IMAGE;
            stage0_r <= {BW{1'b0}};
        end else begin
            mode_r   <= mode_eff_s;
            stage0_r <= {rgb_s, act_s, vif.hsync_in, vif.vsync_in, fs_s};
        end
    end

    generate
        if (LATENCY > 1) begin : g_delay
            vga_delay_line #(
                .WIDTH (BW),
                .DEPTH (LATENCY - 1)
            ) u_delay (
                .clk   (clk),
                .reset (reset),
                .din   (stage0_r),
                .dout  (bundle_s)
            );
        end else begin : g_nodelay
            assign bundle_s = stage0_r;
        end
    endgenerate

    assign vif.VGA_RED     = bundle_s[BW-1 -: COLOR_W];
    assign vif.VGA_GREEN   = bundle_s[BW-1-COLOR_W -: COLOR_W];
    assign vif.VGA_BLUE    = bundle_s[BW-1-2*COLOR_W -: COLOR_W];
    assign vif.de          = bundle_s[3];
    assign vif.VGA_HS      = bundle_s[2];
    assign vif.VGA_VS      = bundle_s[1];
    assign vif.frame_start = bundle_s[0];
    assign vif.mode_q      = mode_r;
endmodule

// File: tb/tb_vga_pixel_stage.sv
// Scoreboard bench: two stage instances (LATENCY 1 and 3) share stimulus and
// are compared against a window/mode reference model.
module tb_vga_pixel_stage;
    localparam int HS = 575;
    localparam int HE = 3135;
    localparam int VS = 31;
    localparam int VE = 511;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vga_pixel_stage_if #(.CNT_W(12), .COLOR_W(4)) if1 ();
    vga_pixel_stage_if #(.CNT_W(12), .COLOR_W(4)) if3 ();

    vga_pixel_stage #(.LATENCY(1)) dut1 (.clk(clk), .reset(reset), .vif(if1));
    vga_pixel_stage #(.LATENCY(3)) dut3 (.clk(clk), .reset(reset), .vif(if3));

    assign if3.H_count   = if1.H_count;
    assign if3.V_count   = if1.V_count;
    assign if3.hsync_in  = if1.hsync_in;
    assign if3.vsync_in  = if1.vsync_in;
    assign if3.red_col   = if1.red_col;
    assign if3.green_col = if1.green_col;
    assign if3.blue_col  = if1.blue_col;
    assign if3.mode_in   = if1.mode_in;
    assign if3.solid_rgb = if1.solid_rgb;

    int checks = 0;
    int passed = 0;
    logic [15:0] q1[$];
    logic [15:0] q3[$];
    logic [1:0]  qm[$];
    bit          mon_en = 1'b0;
    logic [1:0]  model_mode = 2'd0;

    wire [15:0] act1 = {if1.VGA_RED, if1.VGA_GREEN, if1.VGA_BLUE, if1.de, if1.VGA_HS,
                        if1.VGA_VS, if1.frame_start};
    wire [15:0] act3 = {if3.VGA_RED, if3.VGA_GREEN, if3.VGA_BLUE, if3.de, if3.VGA_HS,
                        if3.VGA_VS, if3.frame_start};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h exp=%h", name, got, exp);
    endtask

    // Expected {R,G,B,de,hs,vs,frame_start} from the window and mode rules.
    function automatic logic [15:0] model(input int h, input int v, input logic [1:0] m,
                                          input logic r, input logic g, input logic b,
                                          input logic hs, input logic vs, input logic [11:0] solid);
        bit act;
        int x;
        int y;
        int bar;
        logic [11:0] rgb;
        act = (h >= HS) && (h < HE) && (v >= VS) && (v < VE);
        x   = (h - HS) / 4;
        y   = v - VS;
        rgb = 12'h000;
        if (act) begin
            case (m)
                2'd0: rgb = {{4{r}}, {4{g}}, {4{b}}};
                2'd1: begin
                    bar = (x / 64) % 8;
                    rgb = {(bar >= 4) ? 4'hF : 4'h0, ((bar / 2) % 2 == 1) ? 4'hF : 4'h0,
                           (bar % 2 == 1) ? 4'hF : 4'h0};
                end
                2'd2: rgb = ((((x / 32) % 2) ^ ((y / 32) % 2)) == 1) ? 12'hFFF : 12'h000;
                default: rgb = solid;
            endcase
        end
        return {rgb, act, hs, vs, (h == 0 && v == 0)};
    endfunction

    task automatic apply(input int h, input int v, input logic [1:0] m, input logic r,
                         input logic g, input logic b, input logic hs, input logic vs,
                         input logic [11:0] solid);
        logic [15:0] e;
        @(negedge clk);
        if1.H_count   = 12'(h);
        if1.V_count   = 12'(v);
        if1.mode_in   = m;
        if1.red_col   = r;
        if1.green_col = g;
        if1.blue_col  = b;
        if1.hsync_in  = hs;
        if1.vsync_in  = vs;
        if1.solid_rgb = solid;
        if (h == 0 && v == 0) model_mode = m;
        e = model(h, v, model_mode, r, g, b, hs, vs, solid);
        q1.push_back(e);
        q3.push_back(e);
        qm.push_back(model_mode);
    endtask

    // Monitor: pops expected results as each pipeline presents them.
    initial begin
        logic [15:0] e;
        logic [1:0]  em;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (q1.size() > 0) begin
                    e  = q1.pop_front();
                    em = qm.pop_front();
                    check("lat1_out", act1, e);
                    check("lat1_mode_q", if1.mode_q, em);
                    check("lat3_mode_q", if3.mode_q, em);
                end
                if (q3.size() >= 3) begin
                    e = q3.pop_front();
                    check("lat3_out", act3, e);
                end
            end
        end
    end

    initial begin
        int h;
        int v;
        if1.H_count = 12'd1; if1.V_count = 12'd1; if1.mode_in = 2'd0;
        if1.red_col = 1'b0; if1.green_col = 1'b0; if1.blue_col = 1'b0;
        if1.hsync_in = 1'b0; if1.vsync_in = 1'b0; if1.solid_rgb = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_lat1", act1, 16'h0000);
        check("reset_lat3", act3, 16'h0000);
        check("reset_mode", if1.mode_q, 2'd0);
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Image window edges
        apply(0, 0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        apply(575, 31, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        apply(574, 31, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
        apply(3135, 31, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        apply(3134, 510, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        apply(575, 30, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
        apply(575, 511, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        // Bars
        apply(0, 0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        apply(831, 100, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        apply(2367, 100, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
        apply(1087, 100, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        // Checker
        apply(0, 0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        apply(703, 31, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        apply(703, 63, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        apply(575, 63, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        // Mid-frame mode request waits for the next frame start
        apply(0, 0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'hA5C);
        apply(1000, 200, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'hA5C);
        apply(575, 31, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'hA5C);
        apply(0, 0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'hA5C);
        apply(575, 31, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'hA5C);

        for (int i = 0; i < 3000; i++) begin
            h = int'($urandom_range(0, 3299));
            v = int'($urandom_range(0, 599));
            if ($urandom_range(0, 7) == 0) h = (($urandom_range(0, 1) == 0) ? 574 : 3134) + int'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) v = (($urandom_range(0, 1) == 0) ? 30 : 510) + int'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin h = 0; v = 0; end
            apply(h, v, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 12'($urandom));
        end

        // Asynchronous reset mid-line while showing white
        apply(0, 0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
        repeat (3) apply(575, 31, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("async_rst_lat1", act1, 16'h0000);
        check("async_rst_lat3", act3, 16'h0000);
        check("async_rst_mode", if1.mode_q, 2'd0);
        q1.delete();
        q3.delete();
        qm.delete();
        model_mode = 2'd0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("post_rst_lat1", act1, 16'h0000);
        check("post_rst_lat3", act3, 16'h0000);
        mon_en = 1'b1;
        apply(575, 31, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
        @(posedge clk);
        #3;
        check("post_rst_stale_lat3", act3, 16'h0000);
        apply(831, 100, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000);

        repeat (4) apply(1, 1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/vga_pixel_stage.md
Name: vga_pixel_stage

Overview:
Parametrised VGA colour output stage, replacing the fixed 4-bit, 1-bit-replicate colour register. It gates pixel colour to a configurable active window and offers four frame-synchronous source modes: image, colour bars, checkerboard and solid fill. It delays hsync, vsync and data-enable so they stay aligned with the colour outputs. It sits between the H/V timing counters plus the image pixel source and the VGA pins.

Parameters:
CNT_W, 12, width of H_count/V_count
COLOR_W, 4, bits per colour channel on the pins
H_ACT_START, 575, first active H_count value (inclusive)
H_ACT_END, 3135, first inactive H_count after active region (exclusive)
V_ACT_START, 31, first active V_count value (inclusive)
V_ACT_END, 511, first inactive V_count (exclusive)
PIX_SHIFT, 2, log2(clock ticks per pixel); x = (H_count-H_ACT_START)>>PIX_SHIFT
LATENCY, 1, clocks from counter/sync input to output pins (>=1)
BAR_SHIFT, 6, colour bar width = 2^BAR_SHIFT pixels
CHK_SHIFT, 5, checker square size = 2^CHK_SHIFT pixels/lines

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
H_count  in  CNT_W  horizontal counter
V_count  in  CNT_W  vertical counter
hsync_in  in  1  hsync aligned with H_count
vsync_in  in  1  vsync aligned with H_count
red_col, green_col, blue_col  in  1 each  image pixel bits for current counters
mode_in  in  2  requested mode: 0 image, 1 bars, 2 checker, 3 solid
solid_rgb  in  3*COLOR_W  solid-fill colour {R,G,B}
VGA_RED, VGA_GREEN, VGA_BLUE  out  COLOR_W each  colour pins
VGA_HS, VGA_VS  out  1  delayed syncs
de  out  1  delayed active-window flag
frame_start  out  1  one-cycle pulse, aligned with outputs, at H=0,V=0
mode_q  out  2  mode currently in effect

Behaviour:
- Reset (async, any time, including mid-line):
  - all colour outputs, de, frame_start and mode_q go to 0 immediately.
  - VGA_HS and VGA_VS go to 0.
  - The whole delay pipeline clears; stale pixels never appear after release.
- Active region: act = (H_ACT_START <= H_count < H_ACT_END) && (V_ACT_START <= V_count < V_ACT_END). Unsigned compares at CNT_W.
- Pixel coordinates:
  - x = (H_count - H_ACT_START) >> PIX_SHIFT.
  - y = V_count - V_ACT_START, truncated to CNT_W.
  - Both are used only when act = 1.
- Mode latch: mode_q <= mode_in only on a cycle where H_count == 0 and V_count == 0. A mode change mid-frame takes effect at the next frame start. Stage 0 uses the latched value from the same edge, so the first pixel of a new frame already uses the new mode.
- Colour selection, stage 0, when act = 1:
  - mode 0: each channel = its 1-bit input replicated COLOR_W times.
  - mode 1: bar = x[BAR_SHIFT+2:BAR_SHIFT] (wraps every 8 bars); R = replicate(bar[2]), G = replicate(bar[1]), B = replicate(bar[0]).
  - mode 2: c = x[CHK_SHIFT] ^ y[CHK_SHIFT]; all channels = replicate(c).
  - mode 3: channels = solid_rgb slices (R in the MSBs).
- Outside the active region, all colour bits are 0 in every mode.
- Pipeline: stage 0 registers {colour, act, hsync_in, vsync_in, frame-start flag}. LATENCY-1 further stages delay the whole bundle identically, so an input at edge n appears at outputs after edge n+LATENCY-1. No bypass paths.
- Widths: subtraction results are CNT_W; overflow is impossible inside the active region. No saturation logic.

Decomposition:
- Package vga_pkg holds:
  - mode constants MODE_IMAGE=0, MODE_BARS=1, MODE_CHECK=2, MODE_SOLID=3;
  - default 640x480 timing constants (H/V start/end, PIX_SHIFT).
- Sub-module vga_delay_line (parametrised WIDTH, DEPTH; async active-high reset to 0) implements stages 1..LATENCY-1 for the bundled signals.

Test Plan:
- Image window edges, mode 0, LATENCY=1, red_col=1, others 0:
  - H=575, V=31 -> VGA_RED=4'hF, others 0, de=1 one cycle later.
  - H=574, H=3135, V=30 or V=511 -> all colour 0, de=0.
- Bars, mode 1:
  - H=575+4*64=831, V=100 -> x=64, bar 1 -> BLUE=F, R=G=0.
  - H=575+4*448=2367 -> bar 7 -> all F.
- Checker, mode 2:
  - H=575+4*32=703, V=31 -> 4'hF.
  - H=703, V=63 -> 0.
- Frame-synchronous mode:
  - mode_in 0->3 at H=1000, V=200 -> output stays image until H=0, V=0.
  - At the next frame, frame_start pulses and mode_q=3; H=575, V=31 shows solid_rgb=12'hA5C.
- Alignment with LATENCY=3: hsync_in toggle and colour change at the same edge -> both appear on the pins exactly 2 edges later than they would with LATENCY=1.
- Reset mid-line with outputs 4'hF: assert reset asynchronously -> outputs 0 before the next clock edge. After release, 0 until fresh in-window data passes the pipeline; mode_q=0.
